exp_accel_param: RTL

//   Parametrised fixed-point e^x / e^-x accelerator for x in [0,1), unsigned fraction input.

---
 rtl/exp_accel_param.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/exp_accel_param.sv
// exp_accel_param
//   Iterative fixed-point e^x / e^-x unit for x in [0,1). The Taylor series
//   sum_{k<TERMS} x^k/k! is evaluated in Horner form, one multiply-accumulate
//   per clock, starting from the highest-order coefficient. The accumulator is
//   UQ2.FRAC_W; products are truncated back to FRAC_W fraction bits. In e^-x
//   mode each step subtracts instead of adds, clamping at zero.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request, sampled only while ready=1
//   neg       0: e^x, 1: e^-x (latched with x)
//   x         UQ0.FRAC_W operand
//   ready     high in IDLE or DONE (combinational from state)
//   done      registered one-cycle pulse when a new result is presented
//   intpart   integer part of the latest result
//   fracpart  fraction part of the latest result
module exp_accel_param #(
  parameter int FRAC_W = 16,
  parameter int TERMS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              neg,
  input  logic [FRAC_W-1:0] x,
  output logic              ready,
  output logic              done,
  output logic [1:0]        intpart,
  output logic [FRAC_W-1:0] fracpart
);

  localparam int ACC_W = FRAC_W + 2;
  // k only ever holds TERMS-2 down to 0
  localparam int K_W   = (TERMS > 2) ? $clog2(TERMS - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // floor(2^FRAC_W / k!), evaluated at elaboration; C[0] = C[1] = 1.0
  function automatic logic [ACC_W-1:0] coef(input int k);
    logic [63:0] fact;
    fact = 64'd1;
    for (int i = 2; i <= k; i++) begin
      fact = fact * 64'(i);
    end
    return ACC_W'((64'd1 << FRAC_W) / fact);
  endfunction

  // a - b, clamped to zero when the difference would be negative
  function automatic logic [ACC_W-1:0] sat0(input logic [ACC_W-1:0] a,
                                            input logic [ACC_W-1:0] b);
    logic signed [ACC_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return (diff < 0) ? '0 : diff[ACC_W-1:0];
  endfunction

  logic [ACC_W-1:0] rom [TERMS];

  for (genvar g = 0; g < TERMS; g++) begin : g_rom
    assign rom[g] = coef(g);
  end

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FRAC_W-1:0]   x_l_q, x_l_d;
  logic                neg_l_q, neg_l_d;
  logic                done_q, done_d;
  logic [1:0]          int_q, int_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;

  logic                accept;
  logic [ACC_W-1:0]    c_k;
  logic [ACC_W-1:0]    p_mul;
  logic [FRAC_W-1:0]   prod_lsb_unused;
  logic [ACC_W-1:0]    acc_step;

  assign ready  = (state_q != S_ITER);
  assign accept = ready & start;

  // Horner step: acc*x truncated to FRAC_W fraction bits, then +/- C[k]
  assign {p_mul, prod_lsb_unused} = acc_q * x_l_q;
  assign c_k      = rom[k_q];
  assign acc_step = neg_l_q ? sat0(c_k, p_mul) : (c_k + p_mul);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    x_l_d   = x_l_q;
    neg_l_d = neg_l_q;
    done_d  = 1'b0;
    int_d   = int_q;
    frac_d  = frac_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // DONE accepts exactly like IDLE so operations can run back-to-back
          x_l_d   = x;
          neg_l_d = neg;
          acc_d   = rom[TERMS-1];
          k_d     = K_W'(TERMS - 2);
          state_d = S_ITER;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        acc_d = acc_step;
        if (k_q == '0) begin
          int_d   = acc_step[ACC_W-1:FRAC_W];
          frac_d  = acc_step[FRAC_W-1:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- control and result registers (reset aborts and clears outputs) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      done_q  <= 1'b0;
      int_q   <= '0;
      frac_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
      int_q   <= int_d;
      frac_q  <= frac_d;
    end
  end

  // ---- datapath registers (always reloaded on accept, no reset needed) ----
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    x_l_q   <= x_l_d;
    neg_l_q <= neg_l_d;
  end

  assign done     = done_q;
  assign intpart  = int_q;
  assign fracpart = frac_q;

endmodule
